msp430_ram_ctrl: RTL and testbench
==================================

# msp430_ram_ctrl

Initiator-side controller for the single-port MSP430 data RAM. It accepts word/byte read and write requests on a valid/ready request channel and drives the RAM's active-low chip-enable/write-enable port. Read data returns on a buffered valid/ready response channel. After reset it zero-fills the whole RAM before it accepts any traffic. It sits between the core/bus fabric and the RAM macro.

## Interface
Parameters:
- AW, 7, RAM word-address width
- DW, 16, data width; must be 16, so there are 2 byte lanes
- RSP_DEPTH, 4, response FIFO depth; power of two, minimum 4
- INIT_EN, 1, run the zero-fill sweep after reset when 1

Ports:
- mclk  in  1  clock; single clock domain
- puc_rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_byte_en  in  2  active-high byte lanes for writes; ignored on reads
- req_wdata  in  DW  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DW  read data
- init_done  out  1  sweep complete; high from then until the next reset
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_cen  out  1  RAM chip enable, active-low
- ram_wen  out  2  RAM byte write enables, active-low
- ram_dout  in  DW  RAM read data; valid in the cycle after the cycle in which ram_cen=0 is presented

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT when INIT_EN=1 and RUN when INIT_EN=0.
- INIT behaviour:
  - Writes 0 to word addresses 0 .. 2**AW-1, one word per cycle, with ram_wen=2'b00 and ram_cen=0.
  - The address counter is AW+1 bits. The state moves to RUN after the last word is written.
  - req_ready=0 throughout INIT.
- init_done=1 in RUN.
- All RAM port outputs are registered.
- Write accepted:
  - Next cycle: ram_cen=0, ram_wen=~req_byte_en, ram_addr=req_addr, ram_din=req_wdata.
  - If req_byte_en=2'b00 the write is a no-op: ram_cen stays 1. The request is still accepted.
  - Writes produce no response.
- Read accepted:
  - Next cycle: ram_cen=0, ram_wen=2'b11.
  - Two cycles later ram_dout is pushed into the response FIFO.
- Idle cycles: ram_cen=1, ram_wen=2'b11. ram_addr and ram_din hold their last values.
- Credit counter:
  - Width clog2(RSP_DEPTH)+1. It counts reads in flight plus FIFO occupancy.
  - Increments on read acceptance and decrements on the rsp_valid && rsp_ready handshake. If both happen in the same cycle it is unchanged.
- req_ready = (state==RUN) && (credits < RSP_DEPTH). req_ready does not depend on req_valid or on the payload.
- The FIFO can therefore never overflow. A simultaneous push and pop on a full or empty FIFO must be handled correctly.
- rsp_rdata is the FIFO head. It is stable while rsp_valid=1 and rsp_ready=0.
- Responses return in request order.
- Reset at any time, including mid-sweep or with reads in flight:
  - Drops in-flight reads, empties the FIFO, zeroes credits and restarts INIT.
  - No response from before the reset is ever delivered.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0.
- Sweep duration: first RAM write in the cycle after reset deasserts; init_done=1 after 2**AW cycles of writes (128 by default), i.e. in the cycle after the last write.
- Read latency: request accepted at edge E0 gives rsp_valid=1 in the cycle after E2 (3 cycles), provided the FIFO was empty and unblocked.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.

## Structure
- Package msp430_ram_ctrl_pkg holds:
  - state enum {INIT, RUN}
  - constants RAM_EN=1'b0, RAM_DIS=1'b1, RAM_WEN_NONE=2'b11, RAM_WEN_ALL=2'b00
- Sub-module msp430_ram_rsp_fifo: synchronous FIFO with parameters DW and RSP_DEPTH, and ports push/pop/full/empty/head.
- The top level contains the FSM, the sweep counter, the 2-stage read-tag pipeline and the credit counter.

## Test plan
- Init sweep:
  - Stimulus: reset, then ram_dout driven by a RAM model; check the RAM port.
  - Required: exactly 128 consecutive writes of 0 to addresses 0..127 with ram_wen=2'b00; init_done rises in the cycle after the last write; req_ready=0 until then.
- Byte-masked write:
  - Stimulus: write 0xA5C3 to address 5 with byte_en=2'b11, then write 0x0011 with byte_en=2'b01, then read address 5.
  - Required: rsp_rdata=0xA511, 3 cycles after the read is accepted.
- Back-to-back reads:
  - Stimulus: with rsp_ready=1, read addresses 0..7 on consecutive cycles.
  - Required: 8 in-order responses with one rsp_valid per cycle and no req_ready drop.
- Backpressure:
  - Stimulus: rsp_ready=0, then 6 read requests.
  - Required: exactly 4 accepted; req_ready=0 after the 4th. Raising rsp_ready drains 4 correct responses, then req_ready returns to 1.
- Reset mid-operation:
  - Stimulus: assert puc_rst with 2 reads in flight and 1 buffered response.
  - Required: rsp_valid=0 the next cycle, no stale response ever appears, and the sweep restarts at address 0.
- No-op write:
  - Stimulus: write with byte_en=2'b00.
  - Required: the request is accepted, ram_cen stays 1, and memory contents are unchanged.

Source files
------------

// File: rtl/msp430_ram_ctrl_pkg.sv
// Shared types and RAM port encodings for the MSP430 data RAM controller.
package msp430_ram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic       RAM_EN       = 1'b0;
    localparam logic       RAM_DIS      = 1'b1;
    localparam logic [1:0] RAM_WEN_NONE = 2'b11;
    localparam logic [1:0] RAM_WEN_ALL  = 2'b00;

endpackage

// File: rtl/msp430_ram_rsp_fifo.sv
// Synchronous response FIFO; head reads as zero while empty so the
// consumer never sees stale storage.
module msp430_ram_rsp_fifo #(
    parameter int DW        = 16,
    parameter int RSP_DEPTH = 4
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int PW = $clog2(RSP_DEPTH);

    logic [DW-1:0] mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(RSP_DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; empty gates the head instead.
    always_ff @(posedge mclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/msp430_ram_ctrl.sv
// Request/response front end for the single-port MSP430 data RAM, with a
// post-reset zero-fill sweep and credit-based response flow control.
module msp430_ram_ctrl
    import msp430_ram_ctrl_pkg::*;
#(
    parameter int AW        = 7,
    parameter int DW        = 16,
    parameter int RSP_DEPTH = 4,
    parameter bit INIT_EN   = 1'b1
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_byte_en,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    input  logic [DW-1:0] ram_dout
);

    localparam int     CW          = $clog2(RSP_DEPTH) + 1;
    localparam state_t RESET_STATE = state_t'(INIT_EN ? INIT : RUN);

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   sweep_cnt;
    logic          sweeping;
    logic          rd_fire;
    logic          wr_fire;
    logic          rsp_fire;
    logic          rd_p1;
    logic          rd_p2;
    logic [CW-1:0] credits;
    logic          fifo_full;
    logic          fifo_empty;

    logic          ram_cen_nxt;
    logic [1:0]    ram_wen_nxt;
    logic [AW-1:0] ram_addr_nxt;
    logic [DW-1:0] ram_din_nxt;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (puc_rst) state <= RESET_STATE;
        else         state <= state_nxt;
    end

    // The extra counter bit marks "all words written", one cycle after the last write.
    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep_cnt[AW]) state_nxt = RUN;
    end

    always_comb begin
        init_done = (state == RUN);
        req_ready = (state == RUN) && (credits < CW'(RSP_DEPTH));
    end

    assign sweeping  = (state == INIT) && !sweep_cnt[AW];
    assign rd_fire   = req_valid && req_ready && !req_write;
    assign wr_fire   = req_valid && req_ready &&  req_write;
    assign rsp_valid = !fifo_empty;
    assign rsp_fire  = rsp_valid && rsp_ready;

    always_ff @(posedge mclk) begin
        if (puc_rst)       sweep_cnt <= '0;
        else if (sweeping) sweep_cnt <= sweep_cnt + (AW+1)'(1);
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        ram_cen_nxt  = RAM_DIS;
        ram_wen_nxt  = RAM_WEN_NONE;
        ram_addr_nxt = ram_addr;
        ram_din_nxt  = ram_din;
        if (sweeping) begin
            ram_cen_nxt  = RAM_EN;
            ram_wen_nxt  = RAM_WEN_ALL;
            ram_addr_nxt = sweep_cnt[AW-1:0];
            ram_din_nxt  = '0;
        end else if (rd_fire) begin
            ram_cen_nxt  = RAM_EN;
            ram_addr_nxt = req_addr;
        end else if (wr_fire && |req_byte_en) begin
            ram_cen_nxt  = RAM_EN;
            ram_wen_nxt  = ~req_byte_en;
            ram_addr_nxt = req_addr;
            ram_din_nxt  = req_wdata;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            ram_cen  <= RAM_DIS;
            ram_wen  <= RAM_WEN_NONE;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_cen  <= ram_cen_nxt;
            ram_wen  <= ram_wen_nxt;
            ram_addr <= ram_addr_nxt;
            ram_din  <= ram_din_nxt;
        end
    end

    // rd_p1 tracks the RAM access cycle, rd_p2 the cycle ram_dout is valid.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            rd_p1   <= 1'b0;
            rd_p2   <= 1'b0;
            credits <= '0;
        end else begin
            rd_p1 <= rd_fire;
            rd_p2 <= rd_p1;
            case ({rd_fire, rsp_fire})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    msp430_ram_rsp_fifo #(
        .DW        (DW),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .push      (rd_p2),
        .push_data (ram_dout),
        .pop       (rsp_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rsp_rdata)
    );

    // Credits reserve a slot for every read in flight, so a blocked push cannot occur.
    assert property (@(posedge mclk) disable iff (puc_rst)
        !(fifo_full && rd_p2 && !rsp_fire));

endmodule

// File: tb/tb_msp430_ram_ctrl.sv
// Bench for msp430_ram_ctrl: behavioural RAM plus a memory/queue reference model.
module tb_msp430_ram_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AW;

    logic          mclk = 1'b0;
    logic          puc_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_byte_en = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_cen;
    logic [1:0]    ram_wen;
    logic [DW-1:0] ram_dout = '0;

    logic [DW-1:0] mem     [WORDS];
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] exp_q   [$];
    int            hs_cycles [$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 mclk = ~mclk;

    msp430_ram_ctrl #(
        .AW(AW), .DW(DW), .RSP_DEPTH(DEPTH), .INIT_EN(1'b1)
    ) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_byte_en(req_byte_en), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_dout(ram_dout)
    );

    // One clock cycle: scoreboard and RAM sampling at the falling edge,
    // RAM update at the rising edge, then return 1 time unit after it.
    task automatic step();
        logic          go;
        logic [AW-1:0] pa;
        logic [1:0]    pw;
        logic [DW-1:0] pd;
        logic [DW-1:0] exp;
        @(negedge mclk);
        if (puc_rst) begin
            exp_q.delete();
            for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_data: got unexpected response %h, required none", rsp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (rsp_rdata !== exp) begin
                        errors++;
                        $display("FAIL rsp_data: got %h, required %h", rsp_rdata, exp);
                    end
                end
                hs_cycles.push_back(cyc);
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    for (int b = 0; b < 2; b++)
                        if (req_byte_en[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
        end
        go = !ram_cen; pa = ram_addr; pw = ram_wen; pd = ram_din;
        @(posedge mclk);
        if (go) begin
            ram_dout <= mem[pa];
            for (int b = 0; b < 2; b++)
                if (!pw[b]) mem[pa][b*8 +: 8] = pd[b*8 +: 8];
        end
        #1;
        cyc++;
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [1:0] be,
                          input logic [DW-1:0] d, output int waits);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_byte_en = be; req_wdata = d;
        waits = 0;
        while (!req_ready && waits < 50) begin
            step();
            waits++;
        end
        if (waits < 50) step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        puc_rst = 1'b1;
        step();
        step();
        checks += 8;
        if (req_ready !== 1'b0)   begin errors++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
        if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_rdata !== '0)     begin errors++; $display("FAIL rst_rsp_rdata: got %h, required 0", rsp_rdata); end
        if (init_done !== 1'b0)   begin errors++; $display("FAIL rst_init_done: got %b, required 0", init_done); end
        if (ram_cen !== 1'b1)     begin errors++; $display("FAIL rst_ram_cen: got %b, required 1", ram_cen); end
        if (ram_wen !== 2'b11)    begin errors++; $display("FAIL rst_ram_wen: got %b, required 11", ram_wen); end
        if (ram_addr !== '0)      begin errors++; $display("FAIL rst_ram_addr: got %h, required 0", ram_addr); end
        if (ram_din !== '0)       begin errors++; $display("FAIL rst_ram_din: got %h, required 0", ram_din); end
        puc_rst = 1'b0;
    endtask

    task automatic test_init_sweep();
        int nz = 0;
        for (int i = 0; i < WORDS; i++) begin
            step();
            checks += 2;
            if (ram_cen !== 1'b0 || ram_wen !== 2'b00 || ram_addr !== AW'(i) || ram_din !== '0) begin
                errors++;
                $display("FAIL sweep_write[%0d]: got cen=%b wen=%b addr=%0d din=%h, required cen=0 wen=00 addr=%0d din=0",
                         i, ram_cen, ram_wen, ram_addr, ram_din, i);
            end
            if (req_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL sweep_busy[%0d]: got req_ready=%b init_done=%b, required 0 0", i, req_ready, init_done);
            end
        end
        step();
        checks += 4;
        if (init_done !== 1'b1) begin errors++; $display("FAIL sweep_done: got init_done=%b, required 1", init_done); end
        if (ram_cen !== 1'b1)   begin errors++; $display("FAIL sweep_end_cen: got %b, required 1", ram_cen); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready: got %b, required 1", req_ready); end
        for (int i = 0; i < WORDS; i++) if (mem[i] !== '0) nz++;
        if (nz != 0) begin errors++; $display("FAIL sweep_zero: got %0d nonzero words, required 0", nz); end
    endtask

    task automatic test_byte_write();
        int w;
        int n = 0;
        rsp_ready = 1'b1;
        do_req(1'b1, AW'(5), 2'b11, 16'hA5C3, w);
        do_req(1'b1, AW'(5), 2'b01, 16'h0011, w);
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(5);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bw_ready: got %b, required 1", req_ready); end
        step();
        req_valid = 1'b0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        checks += 2;
        if (n != 2) begin errors++; $display("FAIL bw_latency: got %0d edges after accept, required 2", n); end
        if (rsp_rdata !== 16'hA511) begin errors++; $display("FAIL bw_data: got %h, required a511", rsp_rdata); end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        rsp_ready = 1'b1;
        for (int a = 0; a < 8; a++) do_req(1'b1, AW'(a), 2'b11, 16'($urandom), w);
        drain();
        hs_cycles.delete();
        for (int a = 0; a < 8; a++) begin
            do_req(1'b0, AW'(a), 2'b00, '0, w);
            checks++;
            if (w != 0) begin errors++; $display("FAIL b2b_ready[%0d]: got %0d wait cycles, required 0", a, w); end
        end
        drain();
        checks++;
        if (hs_cycles.size() != 8 || hs_cycles[hs_cycles.size()-1] - hs_cycles[0] != 7) begin
            errors++;
            $display("FAIL b2b_rate: got %0d responses, required 8 on consecutive cycles", hs_cycles.size());
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n = 0;
        drain();
        rsp_ready = 1'b0;
        hs_cycles.delete();
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_addr = AW'(i + 2);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        step(); step(); step();
        checks += 3;
        if (acc != DEPTH)       begin errors++; $display("FAIL bp_accepted: got %0d, required %0d", acc, DEPTH); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b, required 0", req_ready); end
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b, required 1", rsp_valid); end
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        checks += 3;
        if (hs_cycles.size() != DEPTH) begin errors++; $display("FAIL bp_drained: got %0d responses, required %0d", hs_cycles.size(), DEPTH); end
        if (req_ready !== 1'b1)        begin errors++; $display("FAIL bp_ready_back: got %b, required 1", req_ready); end
        if (rsp_valid !== 1'b0)        begin errors++; $display("FAIL bp_empty: got rsp_valid=%b, required 0", rsp_valid); end
    endtask

    task automatic test_noop_write();
        int w;
        logic [DW-1:0] saved;
        drain();
        saved = mem[9];
        do_req(1'b1, AW'(9), 2'b00, ~saved, w);
        checks += 2;
        if (w != 0)           begin errors++; $display("FAIL noop_accept: got %0d wait cycles, required 0", w); end
        if (ram_cen !== 1'b1) begin errors++; $display("FAIL noop_cen: got %b, required 1", ram_cen); end
        step(); step();
        checks++;
        if (mem[9] !== saved) begin errors++; $display("FAIL noop_mem: got %h, required %h", mem[9], saved); end
        do_req(1'b0, AW'(9), 2'b00, '0, w);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid   = 1'($urandom_range(0, 1));
            req_write   = 1'($urandom_range(0, 1));
            req_addr    = AW'($urandom_range(0, 15));
            req_byte_en = 2'($urandom);
            req_wdata   = 16'($urandom);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int stale = 0;
        drain();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(1);
        step();
        req_valid = 1'b0;
        step();
        req_valid = 1'b1; req_addr = AW'(2);
        step();
        req_addr = AW'(3);
        step();
        req_valid = 1'b0;
        puc_rst = 1'b1;
        step();
        checks += 2;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid: got %b, required 0", rsp_valid); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rm_req_ready: got %b, required 0", req_ready); end
        puc_rst = 1'b0;
        step();
        checks++;
        if (ram_cen !== 1'b0 || ram_addr !== '0 || ram_wen !== 2'b00) begin
            errors++;
            $display("FAIL rm_restart: got cen=%b addr=%0d wen=%b, required cen=0 addr=0 wen=00", ram_cen, ram_addr, ram_wen);
        end
        rsp_ready = 1'b1;
        while (!init_done && n < 200) begin
            if (rsp_valid) stale++;
            step();
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) stale++;
            step();
        end
        checks += 2;
        if (n != WORDS) begin errors++; $display("FAIL rm_sweep_len: got %0d cycles, required %0d", n, WORDS); end
        if (stale != 0) begin errors++; $display("FAIL rm_stale: got %0d stale responses, required 0", stale); end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom) | 16'h0001;
        test_reset();
        test_init_sweep();
        test_byte_write();
        test_back_to_back();
        test_backpressure();
        test_noop_write();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
